// File: rtl/conv_pkg.sv
// Shared constants and helpers for the conv core and its post-processing stage.
package conv_pkg;

    localparam int CONV_LEN  = 22;
    localparam int OUT_LEN   = 8;
    localparam int MAX_WIDTH = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pool_state_e;

    // Per-layer requantization right shift.
    function automatic logic [3:0] layer_shift(input logic [1:0] layer);
        case (layer)
            2'd0:    return 4'd8;
            2'd1:    return 4'd10;
            2'd2:    return 4'd12;
            default: return 4'd13;
        endcase
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-width line buffer holding first-row pair maxima for 2x2 pooling.
// One synchronous write port and one combinational read port sharing an address.
module pool_line_buf #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 21
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: storage has no reset; every entry is written on the even row before
    // the odd row reads it, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/conv_pool_quant.sv
// ReLU + 2x2/stride-2 max-pool + per-layer requantize/saturate stage fed by conv.
// Consumes raster-ordered samples; emits one registered activation per pooled pixel.
module conv_pool_quant #(
    parameter int CONV_LEN  = conv_pkg::CONV_LEN,
    parameter int OUT_LEN   = conv_pkg::OUT_LEN,
    parameter int MAX_WIDTH = conv_pkg::MAX_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_start,
    input  logic [1:0]          layer_num,
    input  logic [6:0]          i_width,
    input  logic [6:0]          i_height,
    input  logic                i_valid,
    input  logic [CONV_LEN-1:0] i_conv,
    output logic                o_busy,
    output logic                o_valid,
    output logic [OUT_LEN-1:0]  o_data,
    output logic                o_done
);

    import conv_pkg::*;

    localparam int MAG_W  = CONV_LEN - 1;
    localparam int ADDR_W = $clog2(MAX_WIDTH / 2);

    pool_state_e state, state_nxt;

    logic [1:0]       layer_q;
    logic [6:0]       width_q, height_q;
    logic [6:0]       col, row;
    logic [6:0]       start_w, start_h;
    logic             start_ok, accept, last_sample, lb_we;
    logic [MAG_W-1:0] relu, pair_max, lb_rdata, row_max, col_max, quant;

    assign start_w  = i_width  & 7'h7E;
    assign start_h  = i_height & 7'h7E;
    assign start_ok = i_start && (start_w != 7'd0) && (start_h != 7'd0);

    assign accept      = (state == ST_RUN) && i_valid;
    assign last_sample = (row == height_q - 7'd1) && (col == width_q - 7'd1);
    assign o_busy      = (state == ST_RUN);

    assign relu    = i_conv[CONV_LEN-1] ? '0 : i_conv[MAG_W-1:0];
    // row_max serves both the even-row line-buffer write and the final pooled value.
    assign row_max = (relu > pair_max) ? relu : pair_max;
    assign col_max = (relu > lb_rdata) ? relu : lb_rdata;
    assign lb_we   = accept && !row[0] && col[0];
    assign quant   = row_max >> layer_shift(layer_q);

    pool_line_buf #(
        .DEPTH  (MAX_WIDTH / 2),
        .DATA_W (MAG_W)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .addr  (col[ADDR_W:1]),
        .wdata (row_max),
        .rdata (lb_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next_state gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start_ok)              state_nxt = ST_RUN;
            ST_RUN:  if (accept && last_sample) state_nxt = ST_IDLE;
            default:                            state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            layer_q  <= '0;
            width_q  <= '0;
            height_q <= '0;
            col      <= '0;
            row      <= '0;
            pair_max <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_done   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            o_done  <= 1'b0;
            if (state == ST_IDLE && start_ok) begin
                layer_q  <= layer_num;
                width_q  <= start_w;
                height_q <= start_h;
                col      <= '0;
                row      <= '0;
            end else if (accept) begin
                if (col == width_q - 7'd1) begin
                    col <= '0;
                    row <= row + 7'd1;
                end else begin
                    col <= col + 7'd1;
                end
                if (!col[0]) begin
                    pair_max <= row[0] ? col_max : relu;
                end
                if (row[0] && col[0]) begin
                    o_valid <= 1'b1;
                    o_data  <= (|quant[MAG_W-1:OUT_LEN]) ? '1 : quant[OUT_LEN-1:0];
                    o_done  <= last_sample;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_pool_quant.sv
// Self-checking bench for conv_pool_quant: frame-level pooling model plus
// per-cycle output monitor, directed literal cases and randomized frames.
module tb_conv_pool_quant;

    localparam int CL = 22;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [1:0]    layer_num = '0;
    logic [6:0]    i_width = '0;
    logic [6:0]    i_height = '0;
    logic          i_valid = 1'b0;
    logic [CL-1:0] i_conv = '0;
    logic          o_busy, o_valid, o_done;
    logic [7:0]    o_data;

    always #5 clk = ~clk;

    conv_pool_quant dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (i_start),
        .layer_num (layer_num),
        .i_width   (i_width),
        .i_height  (i_height),
        .i_valid   (i_valid),
        .i_conv    (i_conv),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .o_data    (o_data),
        .o_done    (o_done)
    );

    typedef struct {
        int data;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   got_q[$];
    int   stim[$];
    int   total = 0;
    int   bad = 0;
    bit   exp_busy = 1'b0;
    int   held = 0;
    int   shift_tab[4] = '{8, 10, 12, 13};

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int relu(int v);
        return (v < 0) ? 0 : v;
    endfunction

    // Expected pooled outputs for the first n raster samples of a WxH frame.
    task automatic model(int w, int h, int layer, int n);
        for (int i = 0; i < h / 2; i++) begin
            for (int j = 0; j < w / 2; j++) begin
                int   base;
                int   p;
                exp_t e;
                base = 2 * i * w + 2 * j;
                if (base + w + 1 >= n) continue;
                p = relu(stim[base]);
                if (relu(stim[base + 1]) > p)     p = relu(stim[base + 1]);
                if (relu(stim[base + w]) > p)     p = relu(stim[base + w]);
                if (relu(stim[base + w + 1]) > p) p = relu(stim[base + w + 1]);
                p = p >> shift_tab[layer];
                e.data = (p > 255) ? 255 : p;
                e.last = (n == w * h) && (i == h / 2 - 1) && (j == w / 2 - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        check("drain", exp_q.size(), 0);
    endtask

    task automatic run_frame(int w, int h, int layer, int n, bit gaps, bit mid_start, bit drain);
        int we;
        int he;
        int gap;
        we = w & ~1;
        he = h & ~1;
        if (we != 0 && he != 0) model(we, he, layer, n);
        i_start   = 1'b1;
        i_width   = 7'(w);
        i_height  = 7'(h);
        layer_num = 2'(layer);
        step();
        i_start = 1'b0;
        if (we != 0 && he != 0) exp_busy = 1'b1;
        for (int k = 0; k < n; k++) begin
            gap = gaps ? int'($urandom_range(0, 3)) : 0;
            if (mid_start && k == n / 2) gap = gap + 1;
            for (int g = 0; g < gap; g++) begin
                i_valid = 1'b0;
                if (mid_start && k == n / 2 && g == 0) begin
                    i_start   = 1'b1;
                    i_width   = 7'd6;
                    i_height  = 7'd8;
                    layer_num = ~layer_num;
                end
                step();
                i_start = 1'b0;
            end
            i_valid = 1'b1;
            i_conv  = CL'(stim[k]);
            step();
            if (k == we * he - 1) exp_busy = 1'b0;
        end
        i_valid = 1'b0;
        if (drain) wait_drain();
    endtask

    function automatic int rand_sample();
        case ($urandom_range(0, 3))
            0:       return -int'($urandom_range(1, 2097152));
            1:       return int'($urandom_range(0, 65535));
            2:       return int'($urandom_range(0, 2097151));
            default: return int'($urandom_range(0, 2097151) >> $urandom_range(0, 10));
        endcase
    endfunction

    task automatic fill(int n, int v);
        stim.delete();
        for (int k = 0; k < n; k++) stim.push_back(v);
    endtask

    task automatic randomize_inputs();
        i_start   = 1'($urandom);
        i_valid   = 1'($urandom);
        i_conv    = CL'($urandom);
        i_width   = 7'($urandom);
        i_height  = 7'($urandom);
        layer_num = 2'($urandom);
    endtask

    task automatic quiet_inputs();
        i_start = 1'b0;
        i_valid = 1'b0;
    endtask

    // Per-cycle output monitor against the model queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("rst_valid", o_valid, 0);
            check("rst_data", o_data, 0);
            check("rst_done", o_done, 0);
            check("rst_busy", o_busy, 0);
            held = 0;
        end else begin
            check("busy", o_busy, exp_busy);
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", o_valid, 0);
                    held = o_data;
                end else begin
                    e = exp_q.pop_front();
                    check("data", o_data, e.data);
                    check("done", o_done, e.last);
                    held = e.data;
                    got_q.push_back(o_data);
                end
            end else begin
                check("hold", o_data, held);
                check("done_idle", o_done, 0);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with random inputs, then valids with no start.
        #1;
        for (int c = 0; c < 5; c++) begin
            randomize_inputs();
            step();
        end
        quiet_inputs();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            i_valid = 1'b1;
            i_conv  = CL'($urandom);
            step();
        end
        i_valid = 1'b0;
        step();

        // W=2 H=2 layer 0.
        stim = '{256, 512, 768, 1024};
        got_q.delete();
        run_frame(2, 2, 0, 4, 0, 0, 1);
        check("t1_count", got_q.size(), 1);
        check("t1_value", got_q[0], 4);

        // W=4 H=2 layer 2.
        stim = '{4096, 0, 8192, -5, 12288, 4095, 0, 20480};
        got_q.delete();
        run_frame(4, 2, 2, 8, 0, 0, 1);
        check("t2_count", got_q.size(), 2);
        check("t2_first", got_q[0], 3);
        check("t2_second", got_q[1], 5);

        // Saturation and ReLU.
        fill(4, 2097151);
        got_q.delete();
        run_frame(2, 2, 0, 4, 0, 0, 1);
        check("sat_value", got_q[0], 255);
        stim = '{-1, -2097152, -1, -2097152};
        got_q.delete();
        run_frame(2, 2, 0, 4, 0, 0, 1);
        check("relu_value", got_q[0], 0);

        // Gaps plus an ignored mid-frame start.
        stim = '{256, 512, 768, 1024};
        got_q.delete();
        run_frame(2, 2, 0, 4, 1, 1, 1);
        check("gap_count", got_q.size(), 1);
        check("gap_value", got_q[0], 4);

        // Odd width of 1 collapses to 0: start ignored.
        stim = '{4096, 4096, 4096, 4096};
        got_q.delete();
        run_frame(1, 2, 0, 4, 0, 0, 1);
        check("zero_w_count", got_q.size(), 0);

        // Reset mid-frame after 6 samples, then restart.
        stim.delete();
        for (int k = 0; k < 6; k++) stim.push_back(rand_sample());
        run_frame(4, 4, 1, 6, 0, 0, 0);
        step();
        rst_n = 1'b0;
        exp_busy = 1'b0;
        check("mid_reset_queue", exp_q.size(), 0);
        for (int c = 0; c < 3; c++) begin
            randomize_inputs();
            step();
        end
        quiet_inputs();
        rst_n = 1'b1;
        step();
        fill(4, 8192);
        got_q.delete();
        run_frame(2, 2, 3, 4, 0, 0, 1);
        check("restart_count", got_q.size(), 1);
        check("restart_value", got_q[0], 1);

        // Randomized frames; the first few start in the o_done cycle of the previous one.
        for (int f = 0; f < 8; f++) begin
            int w;
            int h;
            w = 2 * int'($urandom_range(1, 32));
            h = 2 * int'($urandom_range(1, 3));
            if (f == 0) w = 64;
            stim.delete();
            for (int k = 0; k < w * h; k++) stim.push_back(rand_sample());
            run_frame(w, h, int'($urandom_range(0, 3)), w * h, f[0], 0, (f >= 3));
        end
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_pool_quant.md
# conv_pool_quant

Post-processing stage directly downstream of the combinational `conv` core. It consumes one signed `CONV_LEN`-bit convolution result per valid cycle, streamed in raster order, and applies ReLU and 2x2 max-pooling (stride 2). It then requantizes each pooled value with a per-layer right shift and saturates it to an unsigned 8-bit activation for write-back. Frame geometry and layer are latched at frame start; a half-width line buffer holds first-row pair maxima.

## Interface
Parameters:
- `CONV_LEN`, 22: width of the signed input from `conv`.
- `OUT_LEN`, 8: width of the unsigned output activation.
- `MAX_WIDTH`, 64: maximum feature-map width, even.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `i_start`, input, 1: frame start pulse, accepted only in IDLE.
- `layer_num`, input, 2: layer index, latched on accepted `i_start`.
- `i_width`, input, 7: frame width W, latched on start. Must be even and in 2..MAX_WIDTH.
- `i_height`, input, 7: frame height H, latched on start. Must be even and ≥2.
- `i_valid`, input, 1: `i_conv` is valid this cycle.
- `i_conv`, input, CONV_LEN: signed two's-complement conv result.
- `o_busy`, output, 1: high in RUN.
- `o_valid`, output, 1: `o_data` is valid, one-cycle pulse per pooled pixel.
- `o_data`, output, OUT_LEN: pooled, requantized activation.
- `o_done`, output, 1: one-cycle pulse coincident with the last `o_valid` of a frame.

## Operation
- FSM with states IDLE and RUN.
  - IDLE→RUN on `i_start`. Latch `layer_num`, W = `i_width` with LSB forced to 0, and H = `i_height` with LSB forced to 0.
  - If latched W or H is 0, the start is ignored and the FSM stays in IDLE.
  - RUN→IDLE on the cycle the final sample (row H-1, col W-1) is accepted.
- `i_start` in RUN is ignored. `i_valid` in IDLE is ignored. No backpressure: every `i_valid` in RUN is consumed. Gaps between valids are allowed.
- Counters:
  - `col` runs 0..W-1 and wraps to 0 while incrementing `row`.
  - `row` runs 0..H-1.
  - Both reset to 0 on an accepted start.
- ReLU: r = (i_conv < 0) ? 0 : i_conv. This is an unsigned (CONV_LEN-1)-bit value.
- Even row:
  - Even col: `pair_max` ← r.
  - Odd col: line_buf[col>>1] ← max(`pair_max`, r).
- Odd row:
  - Even col: `pair_max` ← max(line_buf[col>>1], r).
  - Odd col: pooled p = max(`pair_max`, r), and an output is issued.
- Requantize: q = p >> SHIFT(layer). SHIFT is 8, 10, 12, 13 for layers 0, 1, 2, 3. `o_data` = (q > 255) ? 255 : q[7:0].
- Line buffer contents are never cleared. Every entry is written on the even row before it is read on the odd row.

## Timing
- Reset values: FSM IDLE, `o_busy` 0, `o_valid` 0, `o_data` 0, `o_done` 0, counters 0, `pair_max` 0.
- Output latency: `o_valid`/`o_data` are registered and appear 1 cycle after the odd-row odd-col sample is accepted. `o_data` holds its value between valids.
- `o_done` is asserted in the same cycle as the frame's last `o_valid`. `o_busy` is already 0 in that cycle.
- A new `i_start` is accepted in the cycle `o_done` is high, which is the first IDLE cycle.
- Reset mid-frame: all state and outputs return to reset values immediately. No partial output is emitted afterwards. The next frame requires a new `i_start`.
- Per frame: (W/2)·(H/2) outputs.

## Structure
- Package `conv_pkg`: `CONV_LEN`, `OUT_LEN`, `MAX_WIDTH`, and the function `layer_shift(layer_num)` that returns the SHIFT table. `conv` and this block share the package.
- Sub-module `pool_line_buf`:
  - MAX_WIDTH/2 entries × (CONV_LEN-1) bits, register array.
  - One synchronous write port and one combinational read port, addressed by `col>>1`.
- Top level holds the FSM, counters, ReLU/max datapath and requant/saturate output register.

## Test plan
- Reset: assert `rst_n`=0 with random inputs → `o_valid`, `o_data`, `o_done` and `o_busy` all 0. Release, then drive `i_valid` without start → no output.
- W=2, H=2, layer 0, inputs 256, 512, 768, 1024 → single `o_valid` with `o_data`=4 one cycle after the 4th sample, and `o_done` in the same cycle.
- W=4, H=2, layer 2:
  - Row 0: 4096, 0, 8192, -5. Row 1: 12288, 4095, 0, 20480.
  - Expected outputs: 3, then 5 (`o_done` with the 5).
- Saturation/ReLU, W=2, H=2, layer 0:
  - All inputs 2^21-1 → 255.
  - All inputs negative (-1, -2^21) → 0.
- Gaps and ignored start: W=2, H=2, layer 0, inputs 256, 512, 768, 1024.
  - Idle cycles between valids, plus an `i_start` pulse mid-frame with different geometry.
  - Expected: one output of 4. Geometry unchanged.
- Reset mid-frame and restart: W=4, H=4; assert reset after 6 samples.
  - Then start W=2, H=2, layer 3, inputs 8192 ×4.
  - Expected: exactly one output of 1. No stale output.
